// File: rtl/vblank_update_sched_pkg.sv
// Shared constants and types for the vblank update scheduler slice.
package vblank_update_sched_pkg;

  localparam int unsigned PROJECTILE_COUNT = 1;
  localparam int unsigned N_UPD_CLIENTS    = 2 + PROJECTILE_COUNT;
  localparam int unsigned CLIENT_PLAYER    = 0;
  localparam int unsigned CLIENT_BOSS      = 1;
  localparam int unsigned CLIENT_PROJ0     = 2;
  localparam int unsigned UPD_TIMEOUT      = 4096;

  typedef enum logic [2:0] {IDLE, SELECT, START, WAIT, FINISH} sched_state_t;

  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/vblank_update_sched_if.sv
// Scheduler-side bus: timing input, client handshake and status outputs.
interface vblank_update_sched_if import vblank_update_sched_pkg::*; #(
  parameter int unsigned N_CLIENTS = N_UPD_CLIENTS,
  parameter int unsigned IDW       = clog2_min1(N_CLIENTS)
);
  logic                 vblnk;
  logic [N_CLIENTS-1:0] client_en;
  logic [N_CLIENTS-1:0] upd_done;
  logic                 ovr_clr;
  logic [N_CLIENTS-1:0] upd_start;
  logic [IDW-1:0]       active_id;
  logic                 busy;
  logic                 frame_done;
  logic                 overrun;
  logic [15:0]          frame_cnt;

  modport slave (
    input  vblnk, client_en, upd_done, ovr_clr,
    output upd_start, active_id, busy, frame_done, overrun, frame_cnt
  );

  modport master (
    output vblnk, client_en, upd_done, ovr_clr,
    input  upd_start, active_id, busy, frame_done, overrun, frame_cnt
  );
endinterface

// File: rtl/vblank_update_sched.sv
// Runs object update clients one at a time during vertical blanking and
// flags frames whose updates timed out or were cut off by active video.
module vblank_update_sched import vblank_update_sched_pkg::*; #(
  parameter int unsigned N_CLIENTS = N_UPD_CLIENTS,
  parameter int unsigned TIMEOUT   = UPD_TIMEOUT,
  parameter int unsigned IDW       = clog2_min1(N_CLIENTS)
) (
  input logic                  clk,
  input logic                  rst,
  vblank_update_sched_if.slave bus
);

  localparam int unsigned IXW = $clog2(N_CLIENTS + 1);
  localparam int unsigned TW  = clog2_min1(TIMEOUT);

  sched_state_t   state_q, state_d;
  logic [IXW-1:0] idx_q, idx_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           vblnk_q;
  logic           overrun_q, overrun_d;
  logic [15:0]    frame_cnt_q, frame_cnt_d;
  logic           en_sel, done_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      vblnk_q     <= 1'b1;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      vblnk_q     <= bus.vblnk;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // idx may equal N_CLIENTS, so the per-client bits are picked by compare
  always_comb begin
    en_sel   = 1'b0;
    done_sel = 1'b0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      if (idx_q == IXW'(i)) begin
        en_sel   = bus.client_en[i];
        done_sel = bus.upd_done[i];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = bus.ovr_clr ? 1'b0 : overrun_q;
    unique case (state_q)
      IDLE: begin
        if (bus.vblnk && !vblnk_q) begin
          state_d = SELECT;
          idx_d   = '0;
        end
      end
      SELECT: begin
        if (!bus.vblnk) begin
          state_d   = IDLE;
          overrun_d = 1'b1;
        end else if (idx_q == IXW'(N_CLIENTS)) begin
          state_d = FINISH;
        end else if (en_sel) begin
          state_d = START;
        end else begin
          idx_d = idx_q + IXW'(1);
        end
      end
      START: begin
        if (!bus.vblnk) begin
          state_d   = IDLE;
          overrun_d = 1'b1;
        end else begin
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (!bus.vblnk) begin
          state_d   = IDLE;
          overrun_d = 1'b1;
        end else if (done_sel) begin
          idx_d   = idx_q + IXW'(1);
          state_d = SELECT;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          overrun_d = 1'b1;
          idx_d     = idx_q + IXW'(1);
          state_d   = SELECT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      FINISH: begin
        frame_cnt_d = frame_cnt_q + 16'd1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Start pulse is decoded from START, which is only entered while vblnk held
  always_comb begin
    bus.upd_start = '0;
    for (int unsigned i = 0; i < N_CLIENTS; i++) begin
      bus.upd_start[i] = (state_q == START) && (idx_q == IXW'(i));
    end
  end

  assign bus.active_id  = (state_q == START || state_q == WAIT) ? IDW'(idx_q) : '0;
  assign bus.busy       = (state_q != IDLE);
  assign bus.frame_done = (state_q == FINISH);
  assign bus.overrun    = overrun_q;
  assign bus.frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_vblank_update_sched.sv
// Self-checking bench: directed frames plus random enable/latency frames
// compared against a per-client timing model of one blanking period.
module tb_vblank_update_sched;
  import vblank_update_sched_pkg::*;

  localparam int unsigned N   = N_UPD_CLIENTS;
  localparam int          TMO = 16;
  localparam int          NEVER = 100000;

  typedef struct {
    int           c;
    logic [N-1:0] vec;
    logic [7:0]   aid;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  int   due[N];
  int   cur_lat[N];
  ev_t  start_q[$];
  int   fd_q[$];
  int   busy_cnt;

  int          exp_cyc[$];
  int          exp_id[$];
  int          exp_fd;
  logic        exp_ovr;
  logic [15:0] exp_fcnt = 16'd0;
  int          last_r;

  vblank_update_sched_if #(.N_CLIENTS(N)) bus ();

  vblank_update_sched #(.N_CLIENTS(N), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: log starts, frame_done and busy; arm each client's done response.
  initial begin : mon
    ev_t e;
    forever begin
      @(negedge clk);
      if (bus.upd_start != '0) begin
        e.c   = cyc;
        e.vec = bus.upd_start;
        e.aid = 8'(bus.active_id);
        start_q.push_back(e);
      end
      for (int i = 0; i < N; i++)
        if (bus.upd_start[i]) due[i] = cyc + cur_lat[i];
      if (bus.frame_done) fd_q.push_back(cyc);
      if (bus.busy) busy_cnt++;
    end
  end

  // Client responder: one-cycle done pulse in the armed cycle.
  initial begin : resp
    bus.upd_done = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) bus.upd_done[i] = (due[i] == cyc);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Walk the clients with cycle arithmetic: first SELECT is the cycle after the rise.
  function automatic void model_frame(input logic [N-1:0] en, input int r);
    int t;
    t = r + 1;
    exp_cyc.delete();
    exp_id.delete();
    exp_ovr = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (en[i]) begin
        exp_cyc.push_back(t + 1);
        exp_id.push_back(i);
        if (cur_lat[i] <= TMO) t = t + cur_lat[i] + 2;
        else begin
          t = t + TMO + 2;
          exp_ovr = 1'b1;
        end
      end else begin
        t = t + 1;
      end
    end
    exp_fd = t + 1;
  endfunction

  task automatic clear_ovr();
    @(posedge clk);
    #1 bus.ovr_clr = 1'b1;
    @(posedge clk);
    #1 bus.ovr_clr = 1'b0;
    check("ovr_clr", bus.overrun, 1'b0);
  endtask

  task automatic run_frame(input logic [N-1:0] en, input int l0, input int l1, input int l2);
    int r;
    int len;
    clear_ovr();
    cur_lat[CLIENT_PLAYER] = l0;
    cur_lat[CLIENT_BOSS]   = l1;
    cur_lat[CLIENT_PROJ0]  = l2;
    for (int i = 0; i < N; i++) due[i] = -1;
    bus.client_en = en;
    start_q.delete();
    fd_q.delete();
    busy_cnt = 0;
    @(posedge clk);
    #1 bus.vblnk = 1'b1;
    r = cyc;
    last_r = r;
    model_frame(en, r);
    exp_fcnt = exp_fcnt + 16'd1;
    len = exp_fd - r + 2;
    repeat (len) @(posedge clk);
    #1 bus.vblnk = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("n_starts", start_q.size(), exp_cyc.size());
    for (int k = 0; k < start_q.size() && k < exp_cyc.size(); k++) begin
      check("start_cycle", start_q[k].c - r, exp_cyc[k] - r);
      check("start_onehot", start_q[k].vec, 1 << exp_id[k]);
      check("active_id", start_q[k].aid, exp_id[k]);
    end
    check("n_frame_done", fd_q.size(), 1);
    if (fd_q.size() > 0) check("frame_done_cycle", fd_q[0] - r, exp_fd - r);
    check("busy_cycles", busy_cnt, exp_fd - r);
    check("frame_cnt", bus.frame_cnt, exp_fcnt);
    check("overrun", bus.overrun, exp_ovr);
  endtask

  initial begin : main
    int r;
    rst           = 1'b1;
    bus.vblnk     = 1'b1;
    bus.client_en = '0;
    bus.ovr_clr   = 1'b0;
    for (int i = 0; i < N; i++) begin
      due[i]     = -1;
      cur_lat[i] = 5;
    end
    busy_cnt = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_upd_start", bus.upd_start, 0);
    check("rst_active_id", bus.active_id, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_frame_done", bus.frame_done, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_frame_cnt", bus.frame_cnt, 0);

    // Release reset with vblnk already high: no frame may start.
    bus.client_en = '1;
    @(posedge clk);
    #1 rst = 1'b0;
    start_q.delete();
    busy_cnt = 0;
    repeat (6) @(posedge clk);
    #1;
    check("no_start_after_rst", start_q.size(), 0);
    check("idle_after_rst", busy_cnt, 0);
    bus.vblnk = 1'b0;
    repeat (2) @(posedge clk);

    run_frame(3'b111, 5, 5, 5);
    if (start_q.size() > 0) check("rise_to_start", start_q[0].c - last_r, 2);
    run_frame(3'b101, 5, 5, 5);
    run_frame(3'b111, 5, NEVER, 5);

    // Abort while waiting on the player client.
    clear_ovr();
    cur_lat[CLIENT_PLAYER] = NEVER;
    for (int i = 0; i < N; i++) due[i] = -1;
    bus.client_en = 3'b001;
    start_q.delete();
    fd_q.delete();
    @(posedge clk);
    #1 bus.vblnk = 1'b1;
    r = cyc;
    repeat (6) @(posedge clk);
    #1 bus.vblnk = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_overrun", bus.overrun, 1);
    check("abort_active_id", bus.active_id, 0);
    check("abort_frame_cnt", bus.frame_cnt, exp_fcnt);
    check("abort_one_start", start_q.size(), 1);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_frame_done", fd_q.size(), 0);
    check("abort_elapsed", cyc - r, 10);
    clear_ovr();

    for (int k = 0; k < 10; k++) begin
      run_frame(N'($urandom_range(0, 7)), $urandom_range(1, TMO + 4),
                $urandom_range(1, TMO + 4), $urandom_range(1, TMO + 4));
    end

    // Frame counter wrap from 16'hFFFF with every client disabled.
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    @(negedge clk);
    check("fcnt_preload", bus.frame_cnt, 16'hFFFF);
    exp_fcnt = 16'hFFFF;
    run_frame(3'b000, 5, 5, 5);
    check("fcnt_wrap", bus.frame_cnt, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
